// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: FSM states, the segment
// lookup table and the blank/dash codes.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Active-high gfedcba patterns; non-decimal codes render as a dash.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  // A digit that stops leading-zero blanking of the digits below it.
  function automatic logic digit_significant(input logic [3:0] i_code);
    return (i_code != 4'd0) && (i_code <= 4'd9);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_decode.sv
// Combinational digit decoder: 4-bit code plus blank flag to active-high segments.
module seg7_decode
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : SEG_LUT[i_code];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display driver that hands binary values to an external
// binary-to-BCD encoder and scans the latched BCD result across the digits.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned ACK_TIMEOUT    = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_value_valid,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  output logic        o_begin_conv,
  output logic [15:0] o_binary,
  input  logic        i_conv_done,
  input  logic [15:0] i_bcd,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  state_t              r_state;
  logic [ACK_W-1:0]    r_ack_cnt;
  logic                r_err;
  logic [15:0]         r_binary;
  logic [3:0]          r_conv_dp;

  logic                r_pend_valid;
  logic [15:0]         r_pend_value;
  logic [3:0]          r_pend_dp;

  logic [15:0]         r_disp_bcd;
  logic [3:0]          r_disp_dp;

  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [1:0]          r_digit;

  logic [6:0]          r_seg;
  logic                r_dp;
  logic [3:0]          r_an;

  logic                w_consume;
  logic [3:0]          w_blank_vec;
  logic                w_above;
  logic [3:0]          w_code;
  logic                w_blank;
  logic [6:0]          w_seg_raw;

  assign w_consume = (r_state == ST_IDLE) && r_pend_valid && i_conv_done;

  // A strobe coinciding with consumption wins, so the new value stays pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
    end else if (i_value_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_value <= i_value;
      r_pend_dp    <= i_dp;
    end else if (w_consume) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ack_cnt  <= '0;
      r_err      <= 1'b0;
      r_binary   <= '0;
      r_conv_dp  <= '0;
      r_disp_bcd <= '0;
      r_disp_dp  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_consume) begin
            r_state   <= ST_START;
            r_binary  <= r_pend_value;
            r_conv_dp <= r_pend_dp;
          end
        end
        ST_START: begin
          r_state   <= ST_WAIT_ACK;
          r_ack_cnt <= '0;
        end
        ST_WAIT_ACK: begin
          if (!i_conv_done) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i_conv_done) begin
            r_state    <= ST_IDLE;
            r_disp_bcd <= i_bcd;
            r_disp_dp  <= r_conv_dp;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Only decimal 1..9 above a zero keeps it lit; dash codes do not count.
  always_comb begin
    w_blank_vec = '0;
    w_above     = 1'b0;
    for (int unsigned k = 3; k >= 1; k--) begin
      w_blank_vec[k] = (r_disp_bcd[4*k +: 4] == 4'd0) && !w_above;
      w_above        = w_above | digit_significant(r_disp_bcd[4*k +: 4]);
    end
  end

  assign w_code  = r_disp_bcd[{r_digit, 2'b00} +: 4];
  assign w_blank = w_blank_vec[r_digit];

  seg7_decode u_decode (
    .i_code  (w_code),
    .i_blank (w_blank),
    .o_seg   (w_seg_raw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_raw ^ {7{SEG_ACTIVE_LOW}};
      r_dp  <= r_disp_dp[r_digit] ^ SEG_ACTIVE_LOW;
      r_an  <= (4'b0001 << r_digit) ^ {4{SEG_ACTIVE_LOW}};
    end
  end

  assign o_begin_conv = (r_state == ST_START);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_binary     = r_binary;
  assign o_err        = r_err;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_an         = r_an;

endmodule
